// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// The fetch and memory stages share one bus through this arbiter.
`ifndef REG_DATA_BUS
`define REG_DATA_BUS 31:0
`endif

package mem_arbiter_pkg;

  localparam int BUS_DATA_WIDTH = 32;
  localparam int BUS_SEL_WIDTH  = 4;
  localparam int CNT_WIDTH      = 8;

  localparam logic [BUS_SEL_WIDTH-1:0] SEL_ALL = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_INST = 2'd2
  } arb_state_t;

  // A requester still needs the bus while its enable is up and its access has not completed.
  function automatic logic pending(input logic cen, input logic done);
    return cen & ~done;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch port, data port and shared-bus signals of the arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding core and memory.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic                      if_cen;
  logic [`REG_DATA_BUS]      if_addr;
  logic                      if_hold;
  logic [`REG_DATA_BUS]      if_inst;
  logic                      if_stall_req;

  logic                      mem_cen;
  logic                      mem_wen;
  logic [`REG_DATA_BUS]      mem_addr;
  logic [`REG_DATA_BUS]      mem_sdata;
  logic [BUS_SEL_WIDTH-1:0]  mem_byte_sel;
  logic                      mem_hold;
  logic [`REG_DATA_BUS]      mem_ldata;
  logic                      mem_stall_req;

  logic                      bus_req;
  logic                      bus_wen;
  logic [BUS_DATA_WIDTH-1:0] bus_addr;
  logic [BUS_DATA_WIDTH-1:0] bus_wdata;
  logic [BUS_SEL_WIDTH-1:0]  bus_byte_sel;
  logic                      bus_ack;
  logic [BUS_DATA_WIDTH-1:0] bus_rdata;
  logic                      bus_err;

  modport slave (
    input  if_cen, if_addr, if_hold,
    output if_inst, if_stall_req,
    input  mem_cen, mem_wen, mem_addr, mem_sdata, mem_byte_sel, mem_hold,
    output mem_ldata, mem_stall_req,
    output bus_req, bus_wen, bus_addr, bus_wdata, bus_byte_sel, bus_err,
    input  bus_ack, bus_rdata
  );

  modport master (
    output if_cen, if_addr, if_hold,
    input  if_inst, if_stall_req,
    output mem_cen, mem_wen, mem_addr, mem_sdata, mem_byte_sel, mem_hold,
    input  mem_ldata, mem_stall_req,
    input  bus_req, bus_wen, bus_addr, bus_wdata, bus_byte_sel, bus_err,
    output bus_ack, bus_rdata
  );

endinterface

// File: rtl/mem_arbiter_bus_timeout_cnt.sv
// Bus wait counter: cleared when a transfer is granted, counts cycles without ACK,
// and flags expiry once LIMIT-1 is reached.
module bus_timeout_cnt
  import mem_arbiter_pkg::*;
#(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(LIMIT - 1);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  assign expired = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and data stages onto one shared memory bus; data accesses win
// because they belong to the older instruction, and a stuck bus is aborted after a timeout.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   arb
);

  arb_state_t state_q, state_d;

  logic                      if_done_q, if_done_d;
  logic                      data_done_q, data_done_d;
  logic [`REG_DATA_BUS]      if_inst_q, if_inst_d;
  logic [`REG_DATA_BUS]      mem_ldata_q, mem_ldata_d;
  logic                      bus_wen_q, bus_wen_d;
  logic [BUS_DATA_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [BUS_DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic [BUS_SEL_WIDTH-1:0]  bus_sel_q, bus_sel_d;
  logic                      bus_err_q, bus_err_d;

  logic if_pend;
  logic data_pend;
  logic busy;
  logic cnt_clear;
  logic cnt_expired;

  assign if_pend   = pending(arb.if_cen, if_done_q);
  assign data_pend = pending(arb.mem_cen, data_done_q);
  assign busy      = (state_q != ST_IDLE);

  bus_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .enable  (busy & ~arb.bus_ack),
    .expired (cnt_expired)
  );

  always_comb begin
    state_d     = state_q;
    if_done_d   = if_done_q;
    data_done_d = data_done_q;
    if_inst_d   = if_inst_q;
    mem_ldata_d = mem_ldata_q;
    bus_wen_d   = bus_wen_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_sel_d   = bus_sel_q;
    bus_err_d   = bus_err_q;
    cnt_clear   = 1'b0;

    // A completed access stays done while its stage is frozen, so it is never re-issued.
    if (data_done_q && !arb.mem_hold) data_done_d = 1'b0;
    if (if_done_q && !arb.if_hold)    if_done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (data_pend) begin
          state_d     = ST_DATA;
          cnt_clear   = 1'b1;
          bus_wen_d   = arb.mem_wen;
          bus_addr_d  = arb.mem_addr;
          bus_wdata_d = arb.mem_wen ? arb.mem_sdata : '0;
          bus_sel_d   = arb.mem_wen ? arb.mem_byte_sel : SEL_ALL;
        end else if (if_pend) begin
          state_d     = ST_INST;
          cnt_clear   = 1'b1;
          bus_wen_d   = 1'b0;
          bus_addr_d  = arb.if_addr;
          bus_wdata_d = '0;
          bus_sel_d   = SEL_ALL;
        end
      end

      ST_DATA: begin
        if (arb.bus_ack) begin
          state_d   = ST_IDLE;
          bus_wen_d = 1'b0;
          if (arb.mem_cen) begin
            data_done_d = 1'b1;
            if (!bus_wen_q) mem_ldata_d = arb.bus_rdata;
          end
        end else if (cnt_expired) begin
          state_d     = ST_IDLE;
          bus_wen_d   = 1'b0;
          bus_err_d   = 1'b1;
          data_done_d = 1'b1;
          if (!bus_wen_q) mem_ldata_d = '0;
        end
      end

      ST_INST: begin
        if (arb.bus_ack) begin
          state_d = ST_IDLE;
          if (arb.if_cen) begin
            if_done_d = 1'b1;
            if_inst_d = arb.bus_rdata;
          end
        end else if (cnt_expired) begin
          state_d   = ST_IDLE;
          bus_err_d = 1'b1;
          if_done_d = 1'b1;
          if_inst_d = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      if_done_q   <= 1'b0;
      data_done_q <= 1'b0;
      if_inst_q   <= '0;
      mem_ldata_q <= '0;
      bus_wen_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_sel_q   <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      if_done_q   <= if_done_d;
      data_done_q <= data_done_d;
      if_inst_q   <= if_inst_d;
      mem_ldata_q <= mem_ldata_d;
      bus_wen_q   <= bus_wen_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_sel_q   <= bus_sel_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign arb.bus_req       = busy;
  assign arb.bus_wen       = bus_wen_q;
  assign arb.bus_addr      = bus_addr_q;
  assign arb.bus_wdata     = bus_wdata_q;
  assign arb.bus_byte_sel  = bus_sel_q;
  assign arb.bus_err       = bus_err_q;
  assign arb.if_inst       = if_inst_q;
  assign arb.mem_ldata     = mem_ldata_q;
  assign arb.if_stall_req  = if_pend;
  assign arb.mem_stall_req = data_pend;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, data-first arbitration, held store, flush,
// timeout and mid-transfer reset, all with hand-computed expectations.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   req_cycles;
  int   wr_cycles;
  int   stall_cycles;

  mem_arbiter_if bus_if ();

  mem_arbiter #(
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .arb (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // One cycle: drive just after the rising edge, then sample on the falling edge.
  task automatic applyStimulus(input logic ic, input logic ih, input logic mc, input logic mw,
                               input logic mh, input logic ack, input logic [31:0] rdata);
    @(posedge clk);
    #1;
    bus_if.if_cen    = ic;
    bus_if.if_hold   = ih;
    bus_if.mem_cen   = mc;
    bus_if.mem_wen   = mw;
    bus_if.mem_hold  = mh;
    bus_if.bus_ack   = ack;
    bus_if.bus_rdata = rdata;
    @(negedge clk);
    if (bus_if.bus_req) req_cycles++;
    if (bus_if.bus_req && bus_if.bus_wen) wr_cycles++;
    if (bus_if.if_stall_req) stall_cycles++;
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    req_cycles   = 0;
    wr_cycles    = 0;
    stall_cycles = 0;
    rst = 1'b1;
    bus_if.if_cen       = 1'b0;
    bus_if.if_addr      = 32'h0;
    bus_if.if_hold      = 1'b0;
    bus_if.mem_cen      = 1'b0;
    bus_if.mem_wen      = 1'b0;
    bus_if.mem_addr     = 32'h0;
    bus_if.mem_sdata    = 32'h0;
    bus_if.mem_byte_sel = 4'h0;
    bus_if.mem_hold     = 1'b0;
    bus_if.bus_ack      = 1'b0;
    bus_if.bus_rdata    = 32'h0;

    repeat (2) @(negedge clk);
    checkOutput("rst_bus_req", 32'(bus_if.bus_req), 32'd0);
    checkOutput("rst_bus_addr", bus_if.bus_addr, 32'h0);
    checkOutput("rst_if_inst", bus_if.if_inst, 32'h0);
    checkOutput("rst_mem_ldata", bus_if.mem_ldata, 32'h0);
    checkOutput("rst_bus_err", 32'(bus_if.bus_err), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] fetch only, ACK on third bus cycle");
    bus_if.if_addr = 32'h0000_0100;
    stall_cycles = 0;
    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("f_c0_stall", 32'(bus_if.if_stall_req), 32'd1);
    checkOutput("f_c0_req", 32'(bus_if.bus_req), 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("f_c1_req", 32'(bus_if.bus_req), 32'd1);
    checkOutput("f_c1_addr", bus_if.bus_addr, 32'h0000_0100);
    checkOutput("f_c1_sel", 32'(bus_if.bus_byte_sel), 32'hF);
    checkOutput("f_c1_wen", 32'(bus_if.bus_wen), 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 1, 32'h2401_0005);
    checkOutput("f_c3_stall", 32'(bus_if.if_stall_req), 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("f_c4_stall", 32'(bus_if.if_stall_req), 32'd0);
    checkOutput("f_c4_inst", bus_if.if_inst, 32'h2401_0005);
    checkOutput("f_c4_req", 32'(bus_if.bus_req), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("f_stall_cycles", 32'(stall_cycles), 32'd4);

    $display("[TB] fetch and load pending together");
    bus_if.if_addr  = 32'h0000_0104;
    bus_if.mem_addr = 32'h0000_0200;
    applyStimulus(1, 0, 1, 0, 0, 0, 32'h0);
    checkOutput("a_c0_mstall", 32'(bus_if.mem_stall_req), 32'd1);
    checkOutput("a_c0_istall", 32'(bus_if.if_stall_req), 32'd1);
    applyStimulus(1, 0, 1, 0, 0, 0, 32'h0);
    checkOutput("a_c1_req", 32'(bus_if.bus_req), 32'd1);
    checkOutput("a_c1_addr", bus_if.bus_addr, 32'h0000_0200);
    checkOutput("a_c1_sel", 32'(bus_if.bus_byte_sel), 32'hF);
    applyStimulus(1, 0, 1, 0, 0, 1, 32'h1111_2222);
    applyStimulus(1, 0, 1, 0, 0, 0, 32'h0);
    checkOutput("a_c3_gap", 32'(bus_if.bus_req), 32'd0);
    checkOutput("a_c3_ldata", bus_if.mem_ldata, 32'h1111_2222);
    checkOutput("a_c3_mstall", 32'(bus_if.mem_stall_req), 32'd0);
    checkOutput("a_c3_istall", 32'(bus_if.if_stall_req), 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("a_c4_req", 32'(bus_if.bus_req), 32'd1);
    checkOutput("a_c4_addr", bus_if.bus_addr, 32'h0000_0104);
    applyStimulus(1, 0, 0, 0, 0, 1, 32'h3333_4444);
    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("a_c6_inst", bus_if.if_inst, 32'h3333_4444);
    checkOutput("a_c6_istall", 32'(bus_if.if_stall_req), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);

    $display("[TB] store with memory stage held");
    bus_if.mem_addr     = 32'h0000_0300;
    bus_if.mem_sdata    = 32'hDEAD_BEEF;
    bus_if.mem_byte_sel = 4'b0011;
    wr_cycles = 0;
    applyStimulus(0, 0, 1, 1, 0, 0, 32'h0);
    checkOutput("s_c0_mstall", 32'(bus_if.mem_stall_req), 32'd1);
    applyStimulus(0, 0, 1, 1, 0, 1, 32'h0);
    checkOutput("s_c1_wen", 32'(bus_if.bus_wen), 32'd1);
    checkOutput("s_c1_wdata", bus_if.bus_wdata, 32'hDEAD_BEEF);
    checkOutput("s_c1_sel", 32'(bus_if.bus_byte_sel), 32'h3);
    checkOutput("s_c1_addr", bus_if.bus_addr, 32'h0000_0300);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 1, 1, 0, 32'h0);
      checkOutput("s_hold_mstall", 32'(bus_if.mem_stall_req), 32'd0);
    end
    applyStimulus(0, 0, 1, 1, 0, 0, 32'h0);
    checkOutput("s_release_mstall", 32'(bus_if.mem_stall_req), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("s_write_count", 32'(wr_cycles), 32'd1);
    checkOutput("s_ldata_kept", bus_if.mem_ldata, 32'h1111_2222);

    $display("[TB] load flushed before ACK");
    bus_if.mem_addr = 32'h0000_0400;
    applyStimulus(0, 0, 1, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 1, 0, 0, 0, 32'h0);
    checkOutput("x_c1_req", 32'(bus_if.bus_req), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h1234_5678);
    bus_if.mem_addr = 32'h0000_0500;
    applyStimulus(0, 0, 1, 0, 0, 0, 32'h0);
    checkOutput("x_c3_req", 32'(bus_if.bus_req), 32'd0);
    checkOutput("x_c3_ldata", bus_if.mem_ldata, 32'h1111_2222);
    checkOutput("x_c3_not_done", 32'(bus_if.mem_stall_req), 32'd1);

    $display("[TB] load with no ACK until timeout");
    req_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 1, 0, 0, 0, 32'h0);
      if (i == 0) checkOutput("t_addr", bus_if.bus_addr, 32'h0000_0500);
    end
    applyStimulus(0, 0, 1, 0, 0, 0, 32'h0);
    checkOutput("t_req_cycles", 32'(req_cycles), 32'd8);
    checkOutput("t_req_dropped", 32'(bus_if.bus_req), 32'd0);
    checkOutput("t_bus_err", 32'(bus_if.bus_err), 32'd1);
    checkOutput("t_ldata", bus_if.mem_ldata, 32'h0);
    checkOutput("t_mstall", 32'(bus_if.mem_stall_req), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("t_err_sticky", 32'(bus_if.bus_err), 32'd1);

    $display("[TB] reset during fetch transfer");
    bus_if.if_addr = 32'h0000_0600;
    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("r_pre_req", 32'(bus_if.bus_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("r_req", 32'(bus_if.bus_req), 32'd0);
    checkOutput("r_addr", bus_if.bus_addr, 32'h0);
    checkOutput("r_sel", 32'(bus_if.bus_byte_sel), 32'h0);
    checkOutput("r_err", 32'(bus_if.bus_err), 32'd0);
    checkOutput("r_inst", bus_if.if_inst, 32'h0);
    checkOutput("r_ldata", bus_if.mem_ldata, 32'h0);
    checkOutput("r_istall", 32'(bus_if.if_stall_req), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("r_reissue_req", 32'(bus_if.bus_req), 32'd1);
    checkOutput("r_reissue_addr", bus_if.bus_addr, 32'h0000_0600);
    applyStimulus(1, 0, 0, 0, 0, 1, 32'hABCD_0001);
    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("r_inst_after", bus_if.if_inst, 32'hABCD_0001);
    checkOutput("r_istall_after", 32'(bus_if.if_stall_req), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
